// File: rtl/float_compare_minmax_seq_pkg.sv
// Shared FPU opcode encodings and format helpers for the compare/min-max unit.
// Contents:
//   fpu_op_e      - 5-bit FPU opcodes; MIN/MAX sit beside SEQ/SLT/SLE
//   canonical_nan - canonical quiet NaN bit pattern for any EXP/MAN width
//                   (returned in a 64-bit container, caller truncates to FLEN)
package float_compare_minmax_seq_pkg;

  typedef enum logic [4:0] {
    FPU_OP_SEQ = 5'h10,
    FPU_OP_SLT = 5'h11,
    FPU_OP_SLE = 5'h12,
    FPU_OP_MIN = 5'h13,
    FPU_OP_MAX = 5'h14
  } fpu_op_e;

  // Sign 0, exponent all ones, mantissa MSB 1, remaining mantissa bits 0:
  // a run of (exp_w + 1) ones placed just below the sign bit.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << (exp_w + 1)) - 64'd1;
    return ones << (man_w - 1);
  endfunction

endpackage

// File: rtl/float_compare_minmax_seq_core.sv
// Combinational classification and ordering of two IEEE-754 operands.
// Ports:
//   a, b      - operands, FLEN = 1 + EXP_WIDTH + MAN_WIDTH bits
//   snan_a/b  - signalling NaN (mantissa MSB clear)
//   qnan_a/b  - quiet NaN (mantissa MSB set)
//   equal     - compare equality (+0 == -0), forced 0 if either is NaN
//   less      - compare a < b, forced 0 if either is NaN
//   a_is_min  - total order a < b with -0 < +0; selects a for MIN, b for MAX
module float_compare_minmax_seq_core #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  localparam int FLEN = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            snan_a,
  output logic            qnan_a,
  output logic            snan_b,
  output logic            qnan_b,
  output logic            equal,
  output logic            less,
  output logic            a_is_min
);

  logic                 sign_a, sign_b;
  logic [EXP_WIDTH-1:0] exp_a, exp_b;
  logic [MAN_WIDTH-1:0] man_a, man_b;
  logic [FLEN-2:0]      mag_a, mag_b;
  logic                 nan_a, nan_b, any_nan, both_zero, total_lt;

  assign sign_a = a[FLEN-1];
  assign sign_b = b[FLEN-1];
  assign exp_a  = a[FLEN-2 -: EXP_WIDTH];
  assign exp_b  = b[FLEN-2 -: EXP_WIDTH];
  assign man_a  = a[MAN_WIDTH-1:0];
  assign man_b  = b[MAN_WIDTH-1:0];
  assign mag_a  = a[FLEN-2:0];
  assign mag_b  = b[FLEN-2:0];

  assign nan_a  = (&exp_a) && (|man_a);
  assign nan_b  = (&exp_b) && (|man_b);
  assign snan_a = nan_a && !man_a[MAN_WIDTH-1];
  assign qnan_a = nan_a &&  man_a[MAN_WIDTH-1];
  assign snan_b = nan_b && !man_b[MAN_WIDTH-1];
  assign qnan_b = nan_b &&  man_b[MAN_WIDTH-1];

  assign any_nan   = nan_a || nan_b;
  assign both_zero = (mag_a == '0) && (mag_b == '0);

  // Sign-magnitude order: negative first; among negatives a larger
  // magnitude is the smaller value. Treats -0 as below +0.
  assign total_lt = (sign_a != sign_b) ? sign_a
                  : (sign_a ? (mag_a > mag_b) : (mag_a < mag_b));

  assign equal    = !any_nan && (both_zero || (a == b));
  assign less     = !any_nan && !both_zero && total_lt;
  assign a_is_min = total_lt;

endmodule

// File: rtl/float_compare_minmax_seq.sv
// Pipelined FPU compare (SEQ/SLT/SLE) and MIN/MAX unit.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   flush                - synchronous clear of all stages and outputs
//   valid_in / ready_out - issue handshake; ready_out only for supported ops
//   valid_out / ready_in - result handshake
//   op, a, b             - opcode and operands
//   int_out              - compare result (0/1), 0 for MIN/MAX
//   float_out            - MIN/MAX result, 0 for compares
//   IV                   - invalid-operation flag
// Results appear STAGES cycles after accept; each stage stalls independently.
module float_compare_minmax_seq
  import float_compare_minmax_seq_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int STAGES    = 1,
  localparam int FLEN = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid_in,
  output logic            ready_out,
  output logic            valid_out,
  input  logic            ready_in,
  input  logic [4:0]      op,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic [31:0]     int_out,
  output logic [FLEN-1:0] float_out,
  output logic            IV
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("float_compare_minmax_seq: STAGES must be 1..3");
  end
  if (FLEN > 64) begin : g_bad_flen
    $error("float_compare_minmax_seq: FLEN above 64 unsupported");
  end

  logic snan_a, qnan_a, snan_b, qnan_b, equal, less, a_is_min;
  logic nan_a, nan_b, any_nan, supported;

  logic [31:0]     int_c;
  logic [FLEN-1:0] float_c;
  logic            iv_c;

  logic [STAGES-1:0] vld_p;
  logic [31:0]       int_p   [STAGES];
  logic [FLEN-1:0]   float_p [STAGES];
  logic              iv_p    [STAGES];

  logic [31:0]       int_src   [STAGES];
  logic [FLEN-1:0]   float_src [STAGES];
  logic              iv_src    [STAGES];

  logic [STAGES:0]   can_load;
  logic [STAGES-1:0] adv, load;

  float_compare_minmax_seq_core #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_core (
    .a        (a),
    .b        (b),
    .snan_a   (snan_a),
    .qnan_a   (qnan_a),
    .snan_b   (snan_b),
    .qnan_b   (qnan_b),
    .equal    (equal),
    .less     (less),
    .a_is_min (a_is_min)
  );

  assign nan_a     = snan_a || qnan_a;
  assign nan_b     = snan_b || qnan_b;
  assign any_nan   = nan_a || nan_b;
  assign supported = op inside {FPU_OP_SEQ, FPU_OP_SLT, FPU_OP_SLE, FPU_OP_MIN, FPU_OP_MAX};

  always_comb begin
    int_c   = '0;
    float_c = '0;
    iv_c    = 1'b0;
    case (op)
      FPU_OP_SEQ: begin
        int_c = {31'd0, equal};
        iv_c  = snan_a || snan_b;
      end
      FPU_OP_SLT: begin
        int_c = {31'd0, less};
        iv_c  = any_nan;
      end
      FPU_OP_SLE: begin
        int_c = {31'd0, less || equal};
        iv_c  = any_nan;
      end
      FPU_OP_MIN, FPU_OP_MAX: begin
        iv_c = snan_a || snan_b;
        if (nan_a && nan_b)   float_c = FLEN'(canonical_nan(EXP_WIDTH, MAN_WIDTH));
        else if (nan_a)       float_c = b;
        else if (nan_b)       float_c = a;
        else if (op == FPU_OP_MIN) float_c = a_is_min ? a : b;
        else                  float_c = a_is_min ? b : a;
      end
      default: ;
    endcase
  end

  // A stage can take new data when it, or any stage after it, has a hole,
  // or when the output is being drained. Written without a ripple chain.
  always_comb begin
    can_load[STAGES] = ready_in;
    for (int i = 0; i < STAGES; i++) begin
      can_load[i] = ready_in;
      for (int j = i; j < STAGES; j++) begin
        if (!vld_p[j]) can_load[i] = 1'b1;
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      adv[i] = vld_p[i] && can_load[i+1];
    end
    load[0] = valid_in && ready_out;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1];
    end
  end

  assign ready_out = supported && can_load[0];

  always_comb begin
    int_src[0]   = int_c;
    float_src[0] = float_c;
    iv_src[0]    = iv_c;
    for (int i = 1; i < STAGES; i++) begin
      int_src[i]   = int_p[i-1];
      float_src[i] = float_p[i-1];
      iv_src[i]    = iv_p[i-1];
    end
  end

  // ---- stage registers p0 .. p(STAGES-1); p0 captures the computed result,
  // later stages are pure delay. An emptied stage is zeroed so the outputs
  // read 0 whenever valid_out is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) begin
        int_p[i]   <= '0;
        float_p[i] <= '0;
        iv_p[i]    <= 1'b0;
      end
    end else if (flush) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) begin
        int_p[i]   <= '0;
        float_p[i] <= '0;
        iv_p[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          vld_p[i]   <= 1'b1;
          int_p[i]   <= int_src[i];
          float_p[i] <= float_src[i];
          iv_p[i]    <= iv_src[i];
        end else if (adv[i]) begin
          vld_p[i]   <= 1'b0;
          int_p[i]   <= '0;
          float_p[i] <= '0;
          iv_p[i]    <= 1'b0;
        end
      end
    end
  end

  assign valid_out = vld_p[STAGES-1];
  assign int_out   = int_p[STAGES-1];
  assign float_out = float_p[STAGES-1];
  assign IV        = iv_p[STAGES-1];

endmodule
